// File: rtl/powerup_pkg.sv
// Shared definitions for the super-speed power-up controller and the I/O glue
// that exposes its status words to the processor.
package powerup_pkg;

    // Controller FSM encoding; also exported on state_dbg
    typedef enum logic [1:0] {
        ST_VISIBLE   = 2'd0,
        ST_ACTIVE_P0 = 2'd1,
        ST_ACTIVE_P1 = 2'd2,
        ST_COOLDOWN  = 2'd3
    } pu_state_e;

    // Coordinate value meaning "sprite not drawn"
    localparam logic [31:0] HIDDEN           = 32'hFFFF_FFFF;

    // Default square sprite edge length in pixels
    localparam logic [31:0] SPRITE_W_DEFAULT = 32'd32;

    // Memory-mapped window used by the I/O glue for power-up status
    localparam logic [31:0] MMIO_ADDR_BASE      = 32'd4200;
    localparam logic [31:0] MMIO_ADDR_P0_STATUS = 32'd4202;
    localparam logic [31:0] MMIO_ADDR_P1_STATUS = 32'd4205;
    localparam logic [31:0] MMIO_ADDR_LAST      = 32'd4205;

endpackage

// File: rtl/aabb_overlap.sv
// Inclusive axis-aligned bounding-box overlap test between a player sprite
// and the power-up sprite. Arithmetic is widened to 33 bits so that a
// HIDDEN coordinate plus the sprite width cannot wrap back into the screen.
module aabb_overlap
    import powerup_pkg::*;
#(
    parameter logic [31:0] SPRITE_W = SPRITE_W_DEFAULT
)
(
    input  logic [31:0] px,
    input  logic [31:0] py,
    input  logic [31:0] ux,
    input  logic [31:0] uy,
    output logic        hit
);

    logic [32:0] px_lo_s;
    logic [32:0] px_hi_s;
    logic [32:0] py_lo_s;
    logic [32:0] py_hi_s;
    logic [32:0] ux_lo_s;
    logic [32:0] ux_hi_s;
    logic [32:0] uy_lo_s;
    logic [32:0] uy_hi_s;
    logic        x_hit_s;
    logic        y_hit_s;

    // Either the far or the near edge of the player lies inside the power-up span, per axis
    always_comb begin
        px_lo_s = {1'b0, px};
        px_hi_s = {1'b0, px} + {1'b0, SPRITE_W};
        py_lo_s = {1'b0, py};
        py_hi_s = {1'b0, py} + {1'b0, SPRITE_W};
        ux_lo_s = {1'b0, ux};
        ux_hi_s = {1'b0, ux} + {1'b0, SPRITE_W};
        uy_lo_s = {1'b0, uy};
        uy_hi_s = {1'b0, uy} + {1'b0, SPRITE_W};

        x_hit_s = ((px_hi_s >= ux_lo_s) && (px_hi_s <= ux_hi_s)) ||
                  ((px_lo_s >= ux_lo_s) && (px_lo_s <= ux_hi_s));
        y_hit_s = ((py_hi_s >= uy_lo_s) && (py_hi_s <= uy_hi_s)) ||
                  ((py_lo_s >= uy_lo_s) && (py_lo_s <= uy_hi_s));

        hit = x_hit_s && y_hit_s;
    end

endmodule

// File: rtl/powerup_controller.sv
// Sequences the shared super-speed power-up between two players: spawn
// position, pickup arbitration (player 0 wins ties), per-owner duration
// timer and respawn cooldown. State advances on the falling clock edge so
// that MMIO reads by the processor see stable values.
module powerup_controller
    import powerup_pkg::*;
#(
    parameter logic [31:0] SPRITE_W        = SPRITE_W_DEFAULT,
    parameter logic [31:0] TICKS_PER_STAGE = 32'd100000000,
    parameter logic [31:0] STAGES          = 32'd7,
    parameter logic [31:0] RESPAWN_TICKS   = 32'd200000000,
    parameter logic [31:0] SPAWN0_X        = 32'd300,
    parameter logic [31:0] SPAWN0_Y        = 32'd300,
    parameter logic [31:0] SPAWN1_X        = 32'd400,
    parameter logic [31:0] SPAWN1_Y        = 32'd400,
    parameter logic [31:0] SPAWN2_X        = 32'd100,
    parameter logic [31:0] SPAWN2_Y        = 32'd400,
    parameter logic [31:0] SPAWN3_X        = 32'd400,
    parameter logic [31:0] SPAWN3_Y        = 32'd100
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] player0_x,
    input  logic [31:0] player0_y,
    input  logic [31:0] player1_x,
    input  logic [31:0] player1_y,
    output logic [31:0] powerup_x,
    output logic [31:0] powerup_y,
    output logic [31:0] player0_powered,
    output logic [31:0] player1_powered,
    output logic [31:0] stage_remaining,
    output logic [1:0]  state_dbg
);

    pu_state_e   state_r;
    logic [1:0]  spawn_idx_r;
    logic [31:0] powerup_x_r;
    logic [31:0] powerup_y_r;
    logic [31:0] p0_powered_r;
    logic [31:0] p1_powered_r;
    logic [31:0] stage_r;
    logic [31:0] tick_r;
    logic [31:0] cool_r;

    logic        hit0_s;
    logic        hit1_s;
    logic [1:0]  next_idx_s;

    // Spawn table lookup, X coordinate
    function automatic logic [31:0] spawn_x(input logic [1:0] idx);
        logic [31:0] v;
        case (idx)
            2'd0:    v = SPAWN0_X;
            2'd1:    v = SPAWN1_X;
            2'd2:    v = SPAWN2_X;
            2'd3:    v = SPAWN3_X;
            default: v = SPAWN0_X;
        endcase
        return v;
    endfunction

    // Spawn table lookup, Y coordinate
    function automatic logic [31:0] spawn_y(input logic [1:0] idx);
        logic [31:0] v;
        case (idx)
            2'd0:    v = SPAWN0_Y;
            2'd1:    v = SPAWN1_Y;
            2'd2:    v = SPAWN2_Y;
            2'd3:    v = SPAWN3_Y;
            default: v = SPAWN0_Y;
        endcase
        return v;
    endfunction

    aabb_overlap #(.SPRITE_W(SPRITE_W)) u_overlap_p0 (
        .px  (player0_x),
        .py  (player0_y),
        .ux  (powerup_x_r),
        .uy  (powerup_y_r),
        .hit (hit0_s)
    );

    aabb_overlap #(.SPRITE_W(SPRITE_W)) u_overlap_p1 (
        .px  (player1_x),
        .py  (player1_y),
        .ux  (powerup_x_r),
        .uy  (powerup_y_r),
        .hit (hit1_s)
    );

    // Spawn index wraps naturally through the 4-entry table
    assign next_idx_s = spawn_idx_r + 2'd1;

    // Power-up sequencing: pickup arbitration, duration timer, cooldown and respawn
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_VISIBLE;
            spawn_idx_r  <= 2'd0;
            powerup_x_r  <= SPAWN0_X;
            powerup_y_r  <= SPAWN0_Y;
            p0_powered_r <= 32'd0;
            p1_powered_r <= 32'd0;
            stage_r      <= 32'd0;
            tick_r       <= 32'd0;
            cool_r       <= 32'd0;
        end else if (enable) begin
            case (state_r)
                ST_VISIBLE: begin
                    if (hit0_s) begin
                        state_r      <= ST_ACTIVE_P0;
                        powerup_x_r  <= HIDDEN;
                        powerup_y_r  <= HIDDEN;
                        p0_powered_r <= 32'd1;
                        stage_r      <= STAGES;
                        tick_r       <= 32'd0;
                    end else if (hit1_s) begin
                        state_r      <= ST_ACTIVE_P1;
                        powerup_x_r  <= HIDDEN;
                        powerup_y_r  <= HIDDEN;
                        p1_powered_r <= 32'd1;
                        stage_r      <= STAGES;
                        tick_r       <= 32'd0;
                    end else begin
                        state_r <= ST_VISIBLE;
                    end
                end
                ST_ACTIVE_P0, ST_ACTIVE_P1: begin
                    if (tick_r == (TICKS_PER_STAGE - 32'd1)) begin
                        tick_r <= 32'd0;
                        if (stage_r == 32'd1) begin
                            p0_powered_r <= 32'd0;
                            p1_powered_r <= 32'd0;
                            stage_r      <= 32'd0;
                            cool_r       <= 32'd0;
                            state_r      <= ST_COOLDOWN;
                        end else begin
                            stage_r <= stage_r - 32'd1;
                        end
                    end else begin
                        tick_r <= tick_r + 32'd1;
                    end
                end
                ST_COOLDOWN: begin
                    if (cool_r == (RESPAWN_TICKS - 32'd1)) begin
                        spawn_idx_r <= next_idx_s;
                        powerup_x_r <= spawn_x(next_idx_s);
                        powerup_y_r <= spawn_y(next_idx_s);
                        state_r     <= ST_VISIBLE;
                    end else begin
                        cool_r <= cool_r + 32'd1;
                    end
                end
                default: begin
                    state_r <= ST_VISIBLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign powerup_x       = powerup_x_r;
    assign powerup_y       = powerup_y_r;
    assign player0_powered = p0_powered_r;
    assign player1_powered = p1_powered_r;
    assign stage_remaining = stage_r;
    assign state_dbg       = state_r;

endmodule

// File: tb/tb_powerup_controller.sv
// Self-checking bench for powerup_controller. Directed scenarios followed by
// randomized play, all compared against a cycle-countdown reference model.
module tb_powerup_controller;

    localparam int TPS     = 4;
    localparam int NSTAGES = 3;
    localparam int RESPAWN = 5;
    localparam int W       = 32;
    localparam logic [31:0] HID = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] player0_x, player0_y, player1_x, player1_y;
    logic [31:0] powerup_x, powerup_y;
    logic [31:0] player0_powered, player1_powered, stage_remaining;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] tab_x [4];
    logic [31:0] tab_y [4];
    int m_owner;   // -1 none, 0 player0, 1 player1
    bit m_hidden;
    int m_left;    // powered cycles remaining
    int m_cool;    // hidden cycles remaining before respawn
    int m_idx;

    powerup_controller #(
        .SPRITE_W        (32'd32),
        .TICKS_PER_STAGE (32'd4),
        .STAGES          (32'd3),
        .RESPAWN_TICKS   (32'd5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .player0_x       (player0_x),
        .player0_y       (player0_y),
        .player1_x       (player1_x),
        .player1_y       (player1_y),
        .powerup_x       (powerup_x),
        .powerup_y       (powerup_y),
        .player0_powered (player0_powered),
        .player1_powered (player1_powered),
        .stage_remaining (stage_remaining),
        .state_dbg       (state_dbg)
    );

    always #5 clock = ~clock;

    function automatic bit axis_hit(input logic [31:0] p, input logic [31:0] u);
        longint a = p;
        longint b = u;
        return ((a + W >= b) && (a + W <= b + W)) || ((a >= b) && (a <= b + W));
    endfunction

    function automatic bit m_overlap(input logic [31:0] px, input logic [31:0] py);
        return axis_hit(px, tab_x[m_idx]) && axis_hit(py, tab_y[m_idx]);
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_hidden = 1'b0;
        m_left   = 0;
        m_cool   = 0;
        m_idx    = 0;
    endtask

    task automatic model_step();
        if (enable) begin
            if (!m_hidden) begin
                if (m_overlap(player0_x, player0_y)) begin
                    m_owner = 0; m_hidden = 1'b1; m_left = NSTAGES * TPS;
                end else if (m_overlap(player1_x, player1_y)) begin
                    m_owner = 1; m_hidden = 1'b1; m_left = NSTAGES * TPS;
                end
            end else if (m_owner >= 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_owner = -1; m_cool = RESPAWN;
                end
            end else begin
                m_cool--;
                if (m_cool == 0) begin
                    m_idx = (m_idx + 1) % 4; m_hidden = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] e_px, e_py, e_st, e_state;
        e_px = m_hidden ? HID : tab_x[m_idx];
        e_py = m_hidden ? HID : tab_y[m_idx];
        e_st = (m_owner >= 0) ? 32'((m_left + TPS - 1) / TPS) : 32'd0;
        if (m_owner == 0)      e_state = 32'd1;
        else if (m_owner == 1) e_state = 32'd2;
        else if (m_hidden)     e_state = 32'd3;
        else                   e_state = 32'd0;
        chk({tag, ".powerup_x"}, powerup_x, e_px);
        chk({tag, ".powerup_y"}, powerup_y, e_py);
        chk({tag, ".p0_powered"}, player0_powered, (m_owner == 0) ? 32'd1 : 32'd0);
        chk({tag, ".p1_powered"}, player1_powered, (m_owner == 1) ? 32'd1 : 32'd0);
        chk({tag, ".stage"}, stage_remaining, e_st);
        chk({tag, ".state"}, {30'd0, state_dbg}, e_state);
    endtask

    // one DUT falling edge, then compare on the following rising edge
    task automatic do_edge(input string tag);
        @(negedge clock);
        model_step();
        @(posedge clock);
        check_outputs(tag);
    endtask

    task automatic set_players(input logic [31:0] ax, input logic [31:0] ay,
                               input logic [31:0] bx, input logic [31:0] by);
        player0_x = ax; player0_y = ay; player1_x = bx; player1_y = by;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        check_outputs("reset");
        reset = 1'b1;
    endtask

    initial begin
        tab_x[0] = 32'd300; tab_y[0] = 32'd300;
        tab_x[1] = 32'd400; tab_y[1] = 32'd400;
        tab_x[2] = 32'd100; tab_y[2] = 32'd400;
        tab_x[3] = 32'd400; tab_y[3] = 32'd100;
        enable = 1'b0;
        set_players(32'd0, 32'd0, 32'd0, 32'd0);
        do_reset();
        enable = 1'b1;

        // player 0 pickup
        set_players(32'd290, 32'd310, 32'd0, 32'd0);
        do_edge("pickup_p0");
        chk("pickup_state_const", {30'd0, state_dbg}, 32'd1);
        chk("pickup_stage_const", stage_remaining, 32'd3);

        // duration: 12 edges to expiry
        for (int i = 0; i < 12; i++) do_edge("duration");
        chk("expiry_state_const", {30'd0, state_dbg}, 32'd3);

        // respawn at (400,400) with player 1 already on the spot
        set_players(32'd0, 32'd0, 32'd410, 32'd390);
        for (int i = 0; i < 5; i++) do_edge("cooldown");
        chk("respawn_x_const", powerup_x, 32'd400);
        do_edge("respawn_pickup_p1");
        chk("p1_powered_const", player1_powered, 32'd1);
        for (int i = 0; i < 3; i++) do_edge("active_p1");

        // asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(posedge clock);
        check_outputs("reset_hold");
        reset = 1'b1;

        // simultaneous pickup, player 0 wins; then freeze mid-active
        set_players(32'd300, 32'd300, 32'd320, 32'd320);
        do_edge("simultaneous");
        for (int i = 0; i < 5; i++) do_edge("sim_active");
        enable = 1'b0;
        for (int i = 0; i < 10; i++) do_edge("freeze");
        chk("freeze_stage_const", stage_remaining, 32'd2);
        enable = 1'b1;
        for (int i = 0; i < 12; i++) do_edge("sim_finish");

        // inclusive boundary at spawn 0
        do_reset();
        set_players(32'd333, 32'd300, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) do_edge("edge_333_miss");
        set_players(32'd332, 32'd300, 32'd0, 32'd0);
        do_edge("edge_332_hit");
        set_players(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd0, 32'd0);
        for (int i = 0; i < 20; i++) do_edge("hidden_far");

        // randomized play
        for (int n = 0; n < 400; n++) begin
            int r0, r1;
            enable = ($urandom_range(0, 9) != 0);
            r0 = $urandom_range(0, 3);
            r1 = $urandom_range(0, 3);
            player0_x = tab_x[r0] + 32'($urandom_range(0, 90)) - 32'd45;
            player0_y = tab_y[r0] + 32'($urandom_range(0, 90)) - 32'd45;
            player1_x = tab_x[r1] + 32'($urandom_range(0, 90)) - 32'd45;
            player1_y = tab_y[r1] + 32'($urandom_range(0, 90)) - 32'd45;
            if ($urandom_range(0, 7) == 0) begin
                player0_x = $urandom;
                player1_y = 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
            end
            do_edge("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/powerup_controller.md
Name: powerup_controller

Overview:
Sequences the single shared super-speed power-up between player 0 and player 1. It owns the power-up's spawn location and pickup detection, arbitrates simultaneous pickups, and runs the per-owner duration timer and the respawn cooldown. Its outputs feed the VGA sprite logic with the power-up position and the processor's memory-mapped status words at 4202 and 4205. It replaces ad-hoc collision and timer logic in the top-level I/O glue.

Parameters:
SPRITE_W, 32, sprite width and height in pixels (players and power-up are square)
TICKS_PER_STAGE, 100000000, clock cycles per duration stage
STAGES, 7, number of stages a pickup lasts
RESPAWN_TICKS, 200000000, cycles hidden after expiry before respawn
SPAWN0_X / SPAWN0_Y ... SPAWN3_X / SPAWN3_Y, 300/300, 400/400, 100/400, 400/100; 4-entry spawn table
HIDDEN, 32'hFFFFFFFF, coordinate value meaning "not drawn"

Ports:
clock  in  1  system clock; all state updates on the falling edge, matching processor MMIO timing
reset  in  1  asynchronous, active-low
enable  in  1  1 = timers and pickup detection run; 0 = freeze all state
player0_x, player0_y  in  32  player 0 top-left position, unsigned
player1_x, player1_y  in  32  player 1 top-left position, unsigned
powerup_x, powerup_y  out  32  power-up top-left position, or HIDDEN
player0_powered, player1_powered  out  32  1 while that player owns an active power-up, else 0
stage_remaining  out  32  stages left for the current owner, 0 when no owner
state_dbg  out  2  current FSM state encoding

Behaviour:
- Reset (reset=0, asynchronous) forces the following, regardless of any operation in progress:
  - state VISIBLE, spawn index 0
  - powerup_x/y = SPAWN0 coordinates
  - powered flags 0, stage_remaining 0
  - tick counter, stage counter and cooldown counter cleared
- FSM states: VISIBLE=0, ACTIVE_P0=1, ACTIVE_P1=2, COOLDOWN=3.
- Overlap test for player p. Inclusive bounds; computed at 33 bits so that HIDDEN+SPRITE_W does not wrap:
  - (px+W >= ux and px+W <= ux+W) or (px >= ux and px <= ux+W)
  - AND the same condition on y.
- VISIBLE, enable=1:
  - If player 0 overlaps → ACTIVE_P0. Player 0 wins when both players overlap on the same edge.
  - Else if player 1 overlaps → ACTIVE_P1.
  - On the transition edge: powerup_x/y ← HIDDEN, owner's powered flag ← 1, stage_remaining ← STAGES, tick counter ← 0. These are visible one edge after the overlapping inputs were sampled.
- ACTIVE_Px, enable=1:
  - Tick counter increments each edge.
  - When tick = TICKS_PER_STAGE-1: tick ← 0, stage_remaining decrements.
  - When stage_remaining=1 and the tick wraps: powered flag ← 0, stage_remaining ← 0, cooldown counter ← 0, → COOLDOWN.
  - The powered flag is therefore high for exactly STAGES×TICKS_PER_STAGE cycles.
  - Overlap is ignored while ACTIVE; the non-owner can never pick up.
- COOLDOWN, enable=1:
  - Cooldown counter increments.
  - At RESPAWN_TICKS-1: spawn index ← (index+1) mod 4, powerup_x/y ← that table entry, → VISIBLE.
  - A player already overlapping the new spawn position picks it up on the following edge, not the spawn edge.
- enable=0: all counters and state hold; outputs unchanged; no pickup.
- Only one owner at a time; at most one of player0_powered / player1_powered is nonzero.
- Counters are 32-bit unsigned. TICKS_PER_STAGE, STAGES and RESPAWN_TICKS must each be ≥1.

Decomposition:
- Shared package powerup_pkg holds:
  - FSM state encodings
  - the HIDDEN constant
  - SPRITE_W default
  - MMIO address constants 4200–4205 for the I/O glue
- One sub-module: aabb_overlap (combinational, 33-bit inclusive overlap test), instantiated once per player.
- Counters and FSM stay in powerup_controller.

Test Plan:
All scenarios use TICKS_PER_STAGE=4, STAGES=3, RESPAWN_TICKS=5, SPRITE_W=32.
1. Reset mid-ACTIVE: drop reset low asynchronously between edges → outputs immediately return to powerup=(300,300), flags 0, state_dbg=0.
2. Player 0 pickup: p0=(290,310), p1=(0,0) → next edge state_dbg=1, powerup=(FFFFFFFF,FFFFFFFF), player0_powered=1, stage_remaining=3.
3. Duration: after pickup, count edges → stage_remaining steps 3→2→1→0 every 4 edges; player0_powered falls exactly 12 edges after the pickup edge; state_dbg=3.
4. Respawn: 5 edges after expiry → powerup=(400,400), state_dbg=0. With p1=(410,390) already overlapping, player1_powered=1 on the next edge.
5. Simultaneous pickup: p0=(300,300), p1=(320,320) → state_dbg=1, player0_powered=1, player1_powered stays 0 throughout the active period.
6. Freeze and boundary: enable=0 for 10 edges during ACTIVE → stage_remaining unchanged. Edge touch p0=(332,300) → pickup occurs (inclusive bound); p0=(333,300) → no pickup. While HIDDEN, p0=(FFFFFFF0,FFFFFFF0) → no pickup.
